panel_controller: RTL

PANEL_CONTROLLER -- requirements
Module: panel_controller

---
 rtl/panel_controller.sv | 99 +++++++++
 1 files changed

// File: rtl/panel_controller.sv
// rtl/panel_controller.sv - front-panel load-address / deposit / examine sequencer
// Switch edges start single memory cycles that borrow the bus while the CPU is halted.
module panel_controller #(
  parameter int WE_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        running,
  input  logic [11:0] swReg,
  input  logic        swLA,
  input  logic        swDep,
  input  logic        swExam,
  input  logic        busGrant,
  input  logic [11:0] ramDataIn,
  output logic        busReq,
  output logic [11:0] memAddr,
  output logic [11:0] memDataOut,
  output logic        memWe,
  output logic        memOe,
  output logic [11:0] panelAddr,
  output logic [11:0] panelData,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, REQ, WR, RD1, RD2, INC} state_t;

  localparam logic [1:0] WE_LAST = 2'(WE_WIDTH - 1);

  state_t      state, state_nxt;
  logic [2:0]  prev_sw;
  logic [1:0]  we_cnt;
  logic        is_dep;
  logic [11:0] wdata;
  logic        accept, la_go, dep_go, exam_go;

  // Edges are only honoured when the panel is idle and the CPU is halted; otherwise dropped.
  assign accept  = (state == IDLE) && !running;
  assign la_go   = accept && swLA && !prev_sw[2];
  assign dep_go  = accept && swDep && !prev_sw[1] && !la_go;
  assign exam_go = accept && swExam && !prev_sw[0] && !la_go && !(swDep && !prev_sw[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dep_go || exam_go) state_nxt = REQ;
      REQ: begin
        if (running)       state_nxt = IDLE;
        else if (busGrant) state_nxt = is_dep ? WR : RD1;
      end
      WR:      if (we_cnt == WE_LAST) state_nxt = INC;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = INC;
      INC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state only, so an asynchronous reset removes them at once.
  always_comb begin
    busReq = (state != IDLE);
    busy   = (state != IDLE);
    memWe  = (state == WR);
    memOe  = (state == RD1) || (state == RD2);
  end

  assign memAddr    = panelAddr;
  assign memDataOut = wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sw   <= 3'b111;
      we_cnt    <= 2'd0;
      is_dep    <= 1'b0;
      wdata     <= 12'd0;
      panelAddr <= 12'd0;
      panelData <= 12'd0;
    end else begin
      prev_sw <= {swLA, swDep, swExam};
      we_cnt  <= (state == WR) ? we_cnt + 2'd1 : 2'd0;
      if (la_go) panelAddr <= swReg;
      if (dep_go) begin
        wdata  <= swReg;
        is_dep <= 1'b1;
      end
      if (exam_go) is_dep <= 1'b0;
      if (state == RD2) panelData <= ramDataIn;
      if (state == INC) begin
        panelAddr <= panelAddr + 12'd1;
        if (is_dep) panelData <= wdata;
      end
    end
  end

endmodule
